mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, giving the max cycles to wait on mem_ready before trapping.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port opcode, input, 7, instruction opcode from the decoder.
REQ-005 SHALL have port funct3, input, 3, instruction funct3 from the decoder.
REQ-006 SHALL have port zero, input, 1, ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-008 SHALL have port ir_write, output, 1, latch instruction register.
REQ-009 SHALL have port pc_write, output, 1, update PC.
REQ-010 SHALL have port pc_src, output, 2: 00 pc+4, 01 pc+imm, 10 ALU result.
REQ-011 SHALL have port mem_read, output, 1, memory read request.
REQ-012 SHALL have port mem_write, output, 1, memory write request.
REQ-013 SHALL have port i_or_d, output, 1: 0 address from PC, 1 address from ALU.
REQ-014 SHALL have port reg_write, output, 1, register file write enable.
REQ-015 SHALL have port wb_sel, output, 2: 00 ALU, 01 memory, 10 pc+4, 11 imm.
REQ-016 SHALL have port alu_src, output, 1: 0 rs2, 1 imm.
REQ-017 SHALL have port alu_op, output, 2: 00 add, 01 branch compare, 10 funct-decoded.
REQ-018 SHALL have port state, output, 3, current FSM state.
REQ-019 SHALL have port trap, output, 1, sticky; set on illegal opcode or memory timeout.
REQ-020 SHALL have port retired, output, 32, count of completed instructions.

Function
REQ-021 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-022 FETCH SHALL assert mem_read with i_or_d=0 and hold until mem_ready.
- On mem_ready, FETCH asserts ir_write and pc_write with pc_src=00 for exactly that cycle, then goes to DECODE.
REQ-023 DECODE SHALL last one cycle.
- Unsupported opcode -> HALT with trap=1.
- 1110011 (system) -> HALT with trap=0.
- Any other supported opcode -> EXEC.
REQ-024 EXEC SHALL drive controls by instruction class:
- R (0110011): alu_src=0, alu_op=10 -> WB.
- I-ALU (0010011): alu_src=1, alu_op=10 -> WB.
- LOAD (0000011) / STORE (0100011): alu_src=1, alu_op=00 -> MEM.
- LUI (0110111) -> WB.
- JAL (1101111): pc_write, pc_src=01 -> WB.
- JALR (1100111): alu_src=1, alu_op=00, pc_write, pc_src=10 -> WB.
- BRANCH (1100011): alu_op=01; pc_write with pc_src=01 iff taken -> FETCH.
REQ-025 Branch taken SHALL be decided by funct3:
- zero for 000 (beq), 101 (bge) and 111 (bgeu).
- !zero for 001 (bne), 100 (blt) and 110 (bltu).
- funct3 010 or 011 -> HALT with trap=1.
REQ-026 MEM SHALL assert i_or_d=1 with mem_read (load) or mem_write (store), held until mem_ready.
- Load -> WB; store -> FETCH.
REQ-027 WB SHALL assert reg_write for one cycle, then go to FETCH.
- wb_sel: 01 load, 10 JAL/JALR, 11 LUI, 00 otherwise.
REQ-028 retired SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB; it wraps 0xFFFFFFFF -> 0.
REQ-029 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
- Reaching MEM_TIMEOUT -> HALT with trap=1, and mem_read/mem_write drop.
REQ-030 HALT SHALL be absorbing until reset; in HALT all enables are 0.
REQ-031 All enables (ir_write, pc_write, mem_read, mem_write, reg_write) SHALL be 0 in any state/class not listed above.
REQ-032 All outputs except state, trap and retired SHALL be combinational from state and the latched instruction class.
REQ-033 opcode and funct3 SHALL be sampled into internal registers at the end of DECODE.

Reset
REQ-034 On rst_n=0, state SHALL become FETCH, trap 0, retired 0 and the wait counter 0, asynchronously, including mid-access.
REQ-035 During reset all enables SHALL be 0; the first mem_read SHALL be issued in the first cycle after rst_n rises.

Structure
REQ-036 A shared package SHALL hold the state encoding, opcode constants, and the alu_op, pc_src and wb_sel encodings.
REQ-037 Instruction class decode (opcode -> class, legal flag) SHALL be one combinational sub-module, mc_class_dec.

Verification
REQ-038 add (0x002081B3), mem_ready=1 in the same cycle -> states 0,1,2,4,0; reg_write high exactly 1 cycle with wb_sel=00; retired=1.
REQ-039 lw with mem_ready delayed 3 cycles in both FETCH and MEM -> mem_read high 4 cycles each; wb_sel=01; total 11 cycles.
REQ-040 beq with zero=1 -> pc_write with pc_src=01 in EXEC; with zero=0 -> no pc_write in EXEC; neither case asserts reg_write.
REQ-041 opcode 0x7F -> HALT, trap=1; all enables stay 0 for 20 subsequent cycles.
REQ-042 mem_ready held 0 in FETCH, MEM_TIMEOUT=8 -> trap=1 after 8 cycles.
REQ-043 rst_n pulsed low during MEM -> FETCH and retired=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, classes, mux selects.
package mc_ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned RET_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_LUI,
    CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_SYSTEM, CLS_NONE
  } cls_e;

  localparam logic [SEL_W-1:0] ALU_ADD    = 2'b00;
  localparam logic [SEL_W-1:0] ALU_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FUNCT  = 2'b10;

  localparam logic [SEL_W-1:0] PC_PLUS4 = 2'b00;
  localparam logic [SEL_W-1:0] PC_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] PC_ALU   = 2'b10;

  localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WB_MEM = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC4 = 2'b10;
  localparam logic [SEL_W-1:0] WB_IMM = 2'b11;

  // Datapath control bundle driven by the controller each cycle
  typedef struct packed {
    logic             ir_write;
    logic             pc_write;
    logic [SEL_W-1:0] pc_src;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             reg_write;
    logic [SEL_W-1:0] wb_sel;
    logic             alu_src;
    logic [SEL_W-1:0] alu_op;
  } ctrl_t;

  // funct3 010/011 have no branch meaning
  function automatic logic br_legal(input logic [F3_W-1:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  // beq/bge/bgeu take on zero, bne/blt/bltu take on !zero
  function automatic logic br_taken(input logic [F3_W-1:0] f3, input logic zero);
    logic taken;
    case (f3)
      3'b000, 3'b101, 3'b111: taken = zero;
      default:                taken = !zero;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_class_dec.sv
// Opcode to instruction class decoder with legality flag.
module mc_class_dec
  import mc_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output cls_e             cls_o,
  output logic             legal_o
);

  // Map each supported opcode to its class; anything else is illegal
  always_comb begin
    cls_o   = CLS_NONE;
    legal_o = 1'b1;
    case (opcode_i)
      OP_R:      cls_o = CLS_R;
      OP_I:      cls_o = CLS_I;
      OP_LOAD:   cls_o = CLS_LOAD;
      OP_STORE:  cls_o = CLS_STORE;
      OP_LUI:    cls_o = CLS_LUI;
      OP_JAL:    cls_o = CLS_JAL;
      OP_JALR:   cls_o = CLS_JALR;
      OP_BRANCH: cls_o = CLS_BRANCH;
      OP_SYSTEM: cls_o = CLS_SYSTEM;
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RISC-V style controller: FETCH/DECODE/EXEC/MEM/WB with memory timeout trap.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [F3_W-1:0]    funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic [SEL_W-1:0]   pc_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic [SEL_W-1:0]   wb_sel,
  output logic               alu_src,
  output logic [SEL_W-1:0]   alu_op,
  output logic [STATE_W-1:0] state,
  output logic               trap,
  output logic [RET_W-1:0]   retired
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic [F3_W-1:0]     funct3_q, funct3_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                trap_q, trap_d;
  logic [RET_W-1:0]    retired_q, retired_d;

  cls_e                dec_cls;
  logic                dec_legal;
  logic [WAIT_W-1:0]   wait_inc;
  logic                wait_hit;
  ctrl_t               ctrl;

  mc_class_dec u_class_dec (
    .opcode_i (opcode),
    .cls_o    (dec_cls),
    .legal_o  (dec_legal)
  );

  assign wait_inc = wait_q + WAIT_W'(1);
  assign wait_hit = (wait_inc == WAIT_W'(MEM_TIMEOUT));

  // Next-state, trap, retire count and memory wait counter
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    funct3_d  = funct3_q;
    trap_d    = trap_q;
    retired_d = retired_q;
    wait_d    = '0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_hit) begin
          state_d = ST_HALT;
          trap_d  = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_DECODE: begin
        cls_d    = dec_cls;
        funct3_d = funct3;
        if (!dec_legal) begin
          state_d = ST_HALT;
          trap_d  = 1'b1;
        end else if (dec_cls == CLS_SYSTEM) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_R, CLS_I, CLS_LUI, CLS_JAL, CLS_JALR: state_d = ST_WB;
          CLS_BRANCH: begin
            if (br_legal(funct3_q)) begin
              state_d   = ST_FETCH;
              retired_d = retired_q + RET_W'(1);
            end else begin
              state_d = ST_HALT;
              trap_d  = 1'b1;
            end
          end
          default: begin
            state_d = ST_HALT;
            trap_d  = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d   = ST_FETCH;
            retired_d = retired_q + RET_W'(1);
          end
        end else if (wait_hit) begin
          state_d = ST_HALT;
          trap_d  = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_WB: begin
        state_d   = ST_FETCH;
        retired_d = retired_q + RET_W'(1);
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d = ST_HALT;
        trap_d  = 1'b1;
      end
    endcase
  end

  // Datapath controls from current state and latched class; enables forced low in reset
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_PLUS4;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R: begin
            ctrl.alu_src = 1'b0;
            ctrl.alu_op  = ALU_FUNCT;
          end
          CLS_I: begin
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALU_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALU_ADD;
          end
          CLS_JAL: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_IMM;
          end
          CLS_JALR: begin
            ctrl.alu_src  = 1'b1;
            ctrl.alu_op   = ALU_ADD;
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_ALU;
          end
          CLS_BRANCH: begin
            ctrl.alu_op   = ALU_BRANCH;
            ctrl.pc_src   = PC_IMM;
            ctrl.pc_write = br_legal(funct3_q) && br_taken(funct3_q, zero);
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (cls_q == CLS_LOAD);
        ctrl.mem_write = (cls_q == CLS_STORE);
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        case (cls_q)
          CLS_LOAD:           ctrl.wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR:  ctrl.wb_sel = WB_PC4;
          CLS_LUI:            ctrl.wb_sel = WB_IMM;
          default:            ctrl.wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
    if (!rst_n) begin
      ctrl.ir_write  = 1'b0;
      ctrl.pc_write  = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.reg_write = 1'b0;
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_NONE;
      funct3_q  <= '0;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      funct3_q  <= funct3_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  assign ir_write  = ctrl.ir_write;
  assign pc_write  = ctrl.pc_write;
  assign pc_src    = ctrl.pc_src;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign i_or_d    = ctrl.i_or_d;
  assign reg_write = ctrl.reg_write;
  assign wb_sel    = ctrl.wb_sel;
  assign alu_src   = ctrl.alu_src;
  assign alu_op    = ctrl.alu_op;
  assign state     = state_q;
  assign trap      = trap_q;
  assign retired   = retired_q;

endmodule
